// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states,
// opcodes, mux selects and the packed strobe bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational strobe decode: current state plus mem_ready to the
// datapath control bundle. Unused state codes decode to all-zero.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]        state_i,
  input  logic              mem_ready_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t c;

  always_comb begin
    c           = '0;
    c.alu_src_b = SRCB_B;
    c.alu_op    = ALUOP_ADD;
    c.pc_source = PCSRC_ALU;
    case (state_t'(state_i))
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.ir_write  = mem_ready_i;
        c.pc_write  = mem_ready_i;
      end
      S_DECODE:   c.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write  = 1'b1;
        c.iord       = 1'b1;
        c.instr_done = mem_ready_i;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, latched opcode and
// next-state logic; strobes come from mips_ctrl_decode and are forced low in reset.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state_o,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic              illegal_d;
  logic [CTRL_W-1:0] ctrl_raw;
  ctrl_t             ctrl;
  logic              run;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // lw and sw share the address cycle; the latched opcode picks the access.
      S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_raw)
  );

  assign ctrl = ctrl_raw;
  assign run  = ~reset;

  assign PCWrite     = run & ctrl.pc_write;
  assign PCWriteCond = run & ctrl.pc_write_cond;
  assign IorD        = run & ctrl.iord;
  assign MemRead     = run & ctrl.mem_read;
  assign MemWrite    = run & ctrl.mem_write;
  assign IRWrite     = run & ctrl.ir_write;
  assign MemtoReg    = run & ctrl.mem_to_reg;
  assign RegDst      = run & ctrl.reg_dst;
  assign RegWrite    = run & ctrl.reg_write;
  assign ALUSrcA     = run & ctrl.alu_src_a;
  assign ALUSrcB     = {2{run}} & ctrl.alu_src_b;
  assign ALUOp       = {2{run}} & ctrl.alu_op;
  assign PCSource    = {2{run}} & ctrl.pc_source;
  assign state_o     = {4{run}} & state_q;
  assign instr_done  = run & ctrl.instr_done;
  assign illegal_op  = run & illegal_d;

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcs;
    logic       done, ill;
  } obs_t;

  typedef struct {
    bit         rst;
    bit         mr;
    logic [5:0] op;
    obs_t       exp;
    int         txn;
    bit         last;
  } cyc_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_o;

  cyc_t plan[$];
  cyc_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_id = 0;
  bit   stim_done = 1'b0;

  always #5 clock = ~clock;

  mips_multicycle_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state_o(state_o), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  function automatic bit is_legal(logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
  endfunction

  function automatic obs_t model(int st, bit mr, bit ill);
    obs_t e = '0;
    e.st = st[3:0];
    case (st)
      0:  begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
      1:  begin e.srcb = 2'b11; e.ill = ill; end
      2:  begin e.srca = 1; e.srcb = 2'b10; end
      3:  begin e.mrd = 1; e.iord = 1; end
      4:  begin e.rw = 1; e.m2r = 1; e.done = 1; end
      5:  begin e.mwr = 1; e.iord = 1; e.done = mr; end
      6:  begin e.srca = 1; e.aluop = 2'b10; end
      7:  begin e.rw = 1; e.rdst = 1; e.done = 1; end
      8:  begin e.srca = 1; e.aluop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; e.done = 1; end
      9:  begin e.pcw = 1; e.pcs = 2'b10; e.done = 1; end
      10: begin e.srca = 1; e.srcb = 2'b10; end
      11: begin e.rw = 1; e.done = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic push(bit rst, bit mr, logic [5:0] op, obs_t e, bit last);
    cyc_t c;
    c.rst = rst; c.mr = mr; c.op = op; c.exp = e; c.txn = txn_id; c.last = last;
    plan.push_back(c);
  endtask

  task automatic add_st(int st, bit mr, logic [5:0] op, bit ill);
    obs_t e = model(st, mr, ill);
    push(1'b0, mr, op, e, e.done | e.ill);
  endtask

  task automatic add_reset();
    push(1'b1, 1'($urandom_range(0, 1)), 6'($urandom), '0, 1'b1);
  endtask

  task automatic rnd_st(int st);
    add_st(st, 1'($urandom_range(0, 1)), 6'($urandom), 1'b0);
  endtask

  task automatic run_instr(logic [5:0] op, int fw, int mw, int abort);
    int mst;
    txn_id++;
    for (int i = 0; i < fw; i++) add_st(0, 1'b0, 6'($urandom), 1'b0);
    add_st(0, 1'b1, 6'($urandom), 1'b0);
    add_st(1, 1'($urandom_range(0, 1)), op, !is_legal(op));
    if (!is_legal(op)) return;
    case (op)
      6'b000000: begin rnd_st(6); rnd_st(7); end
      6'b000100: rnd_st(8);
      6'b000010: rnd_st(9);
      6'b001000: begin rnd_st(10); rnd_st(11); end
      default: begin
        mst = (op == 6'b100011) ? 3 : 5;
        rnd_st(2);
        if (abort >= 0) begin
          for (int i = 0; i < abort; i++) add_st(mst, 1'b0, 6'($urandom), 1'b0);
          add_reset();
          return;
        end
        for (int i = 0; i < mw; i++) add_st(mst, 1'b0, 6'($urandom), 1'b0);
        add_st(mst, 1'b1, 6'($urandom), 1'b0);
        if (mst == 3) rnd_st(4);
      end
    endcase
  endtask

  task automatic build_plan();
    logic [5:0] legal_ops [6];
    logic [5:0] op;
    int         k;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    push(1'b1, 1'b1, 6'h00, '0, 1'b0);
    push(1'b1, 1'b1, 6'h00, '0, 1'b0);
    run_instr(6'b000000, 0, 0, -1);
    run_instr(6'b100011, 2, 3, -1);
    run_instr(6'b101011, 0, 0, -1);
    run_instr(6'b000100, 0, 0, -1);
    run_instr(6'b000010, 0, 0, -1);
    run_instr(6'b111111, 0, 0, -1);
    run_instr(6'b100011, 0, 0, 2);
    run_instr(6'b001000, 1, 0, -1);
    run_instr(6'b101011, 0, 2, -1);
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 6);
      if (k < 6) op = legal_ops[k];
      else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      if (op == 6'b100011 && $urandom_range(0, 9) == 0)
        run_instr(op, $urandom_range(0, 2), 0, $urandom_range(0, 2));
      else
        run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    cyc_t c;
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'h00;
    build_plan();
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge clock);
      #1;
      reset = c.rst; mem_ready = c.mr; opcode = c.op;
      sb.push_back(c);
    end
    @(posedge clock);
    #1;
    stim_done = 1'b1;
  end

  initial begin
    cyc_t c;
    obs_t act;
    int   cyc = 0;
    while (!(stim_done && sb.size() == 0)) begin
      @(negedge clock);
      cyc++;
      if (sb.size() > 0) begin
        c = sb.pop_front();
        act = {state_o, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, illegal_op};
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL cycle_outputs txn=%0d cycle=%0d rst=%0b mr=%0b actual=%h required=%h",
                   c.txn, cyc, c.rst, c.mr, act, c.exp);
        end
        checks++;
        if (state_o !== c.exp.st) begin
          errors++;
          $display("FAIL state txn=%0d cycle=%0d actual=%0d required=%0d",
                   c.txn, cyc, state_o, c.exp.st);
        end
        checks++;
        if ({RegWrite, MemWrite, PCWrite, PCWriteCond, IRWrite} !==
            {c.exp.rw, c.exp.mwr, c.exp.pcw, c.exp.pcwc, c.exp.irw}) begin
          errors++;
          $display("FAIL write_strobes txn=%0d cycle=%0d actual=%b required=%b",
                   c.txn, cyc, {RegWrite, MemWrite, PCWrite, PCWriteCond, IRWrite},
                   {c.exp.rw, c.exp.mwr, c.exp.pcw, c.exp.pcwc, c.exp.irw});
        end
        checks++;
        if ({instr_done, illegal_op} !== {c.exp.done, c.exp.ill}) begin
          errors++;
          $display("FAIL pulses txn=%0d cycle=%0d actual=%b required=%b",
                   c.txn, cyc, {instr_done, illegal_op}, {c.exp.done, c.exp.ill});
        end
        if (c.last)
          $display("txn %0d ends cycle %0d: state=%0d done=%0b illegal=%0b reset=%0b",
                   c.txn, cyc, state_o, instr_done, illegal_op, c.rst);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
